// File: rtl/isqrt_pipe_param_if.sv
// rtl/isqrt_pipe_param_if.sv - operand/result bundle for the pipelined integer square root
//
// Parameters: n radicand width, tag_w sideband tag width.
// Signals (master = surrounding logic, slave = the sqrt pipe):
//   en         pipeline enable; 0 freezes every stage
//   arg_vld    operand valid
//   arg        unsigned radicand, n bits
//   arg_tag    sideband tag captured with arg
//   res_vld    result valid
//   res        floor(sqrt(arg)), n/2 bits
//   res_tag    tag of the operand that produced res
//   in_flight  number of valid entries inside the pipe
//   res_rem    arg - res*res, present only when ISQRT_PIPE_REMAINDER_EN is defined
interface isqrt_pipe_param_if #(
  parameter int n     = 32,
  parameter int tag_w = 4
);
  localparam int cnt_w = $clog2(n / 2 + 1);

  logic             en;
  logic             arg_vld;
  logic [n-1:0]     arg;
  logic [tag_w-1:0] arg_tag;
  logic             res_vld;
  logic [n/2-1:0]   res;
  logic [tag_w-1:0] res_tag;
  logic [cnt_w-1:0] in_flight;
`ifdef ISQRT_PIPE_REMAINDER_EN
  logic [n/2:0]     res_rem;
`endif

  modport master (
    output en, arg_vld, arg, arg_tag,
`ifdef ISQRT_PIPE_REMAINDER_EN
    input  res_rem,
`endif
    input  res_vld, res, res_tag, in_flight
  );

  modport slave (
    input  en, arg_vld, arg, arg_tag,
`ifdef ISQRT_PIPE_REMAINDER_EN
    output res_rem,
`endif
    output res_vld, res, res_tag, in_flight
  );
endinterface

// File: rtl/isqrt_pipe_param.sv
// rtl/isqrt_pipe_param.sv - fully pipelined floor(sqrt) with sideband tag, stall and occupancy count
//
// Parameters:
//   n      radicand width, even and >= 4
//   tag_w  sideband tag width
// Ports:
//   clk    clock
//   rst    asynchronous active-low reset
//   bus    isqrt_pipe_param_if.slave
//          in : en, arg_vld, arg, arg_tag
//          out: res_vld, res, res_tag, in_flight, res_rem (optional)
// Optional feature macro: ISQRT_PIPE_REMAINDER_EN registers and exposes res_rem.
//
// n/2 stages; stage k resolves root bit n/2-1-k with a restoring bit-pair
// recurrence. A result appears n/2 enabled cycles after its operand is presented.
module isqrt_pipe_param #(
  parameter int n     = 32,
  parameter int tag_w = 4
) (
  input  logic              clk,
  input  logic              rst,
  isqrt_pipe_param_if.slave bus
);
  localparam int s  = n / 2;
  localparam int rw = s + 1;          // remainder register width
  localparam int ww = s + 3;          // shifted remainder / trial working width
  localparam int cw = $clog2(s + 1);
  localparam logic [cw-1:0] cnt_max = cw'(s);

  if (n < 4 || (n % 2) != 0) begin : g_bad_n
    $error("isqrt_pipe_param: n must be even and >= 4");
  end

  for (genvar k = 0; k < s; k++) begin : g_stage
    // radicand bits still to be consumed when entering this stage
    localparam int in_w = n - 2 * k;

    logic             vld_in;
    logic [tag_w-1:0] tag_in;
    logic [s-1:0]     root_in;
    logic [rw-1:0]    rem_in;
    logic [in_w-1:0]  rad_in;
    logic [ww-1:0]    rem_sh;
    logic [ww-1:0]    trial;
    logic             fit;
    logic [s-1:0]     root_nx;

    logic             vld_q;
    logic [tag_w-1:0] tag_q;
    logic [s-1:0]     root_q;

    if (k == 0) begin : g_src
      assign vld_in  = bus.arg_vld;
      assign tag_in  = bus.arg_tag;
      assign root_in = '0;
      assign rem_in  = '0;
      assign rad_in  = bus.arg;
    end else begin : g_src
      assign vld_in  = g_stage[k-1].vld_q;
      assign tag_in  = g_stage[k-1].tag_q;
      assign root_in = g_stage[k-1].root_q;
      assign rem_in  = g_stage[k-1].g_mid.rem_q;
      assign rad_in  = g_stage[k-1].g_mid.rad_q;
    end

    assign rem_sh  = {rem_in, rad_in[in_w-1 -: 2]};
    assign trial   = {1'b0, root_in, 2'b01};
    assign fit     = (rem_sh >= trial);
    // root_in never uses its MSB before the last stage, so the shift loses nothing
    assign root_nx = s'({root_in, fit});

    // The final stage only loads on a valid entry so res/res_tag hold across bubbles.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q  <= 1'b0;
        tag_q  <= '0;
        root_q <= '0;
      end else if (bus.en) begin
        vld_q <= vld_in;
        if (k < s - 1 || vld_in) begin
          tag_q  <= tag_in;
          root_q <= root_nx;
        end
      end
    end

    if (k < s - 1) begin : g_mid
      logic [rw-1:0]   rem_nx;
      logic [rw-1:0]   rem_q;
      logic [in_w-3:0] rad_q;

      // rem stays <= 2*root, so the top bits of the working width are always zero here
      assign rem_nx = rw'(fit ? rem_sh - trial : rem_sh);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rem_q <= '0;
          rad_q <= '0;
        end else if (bus.en) begin
          rem_q <= rem_nx;
          rad_q <= rad_in[in_w-3:0];
        end
      end
    end
`ifdef ISQRT_PIPE_REMAINDER_EN
    else begin : g_last
      logic [rw-1:0] rem_nx;
      logic [rw-1:0] rem_q;

      assign rem_nx = rw'(fit ? rem_sh - trial : rem_sh);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rem_q <= '0;
        end else if (bus.en && vld_in) begin
          rem_q <= rem_nx;
        end
      end
    end
`endif
  end

  assign bus.res_vld = g_stage[s-1].vld_q;
  assign bus.res     = g_stage[s-1].root_q;
  assign bus.res_tag = g_stage[s-1].tag_q;
`ifdef ISQRT_PIPE_REMAINDER_EN
  assign bus.res_rem = g_stage[s-1].g_last.rem_q;
`endif

  // Occupancy: an entry leaves when the final stage holds a valid result on an enabled edge.
  logic [cw-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (bus.en) begin
      if (bus.arg_vld && !bus.res_vld) begin
        cnt_q <= cnt_q + cw'(1);
      end else if (!bus.arg_vld && bus.res_vld) begin
        cnt_q <= cnt_q - cw'(1);
      end
    end
  end

  assign bus.in_flight = cnt_q;

  in_flight_bound: assert property (@(posedge clk) disable iff (!rst) cnt_q <= cnt_max);

endmodule
